// File: rtl/vit_trb_engine_pkg.sv
// ============================================================================
//  Module   : vit_trb_engine_pkg
//  Purpose  : Shared types and constants for the Viterbi traceback engine.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package vit_trb_engine_pkg;

  // Default decoder geometry; the engine itself is parameterised.
  localparam int c_STATE_W = 6;
  localparam int c_ADDR_W  = 8;

  typedef logic [c_STATE_W-1:0] trb_state_t;
  typedef logic [c_ADDR_W-1:0]  trb_addr_t;

  // Decision RAM read latency in enabled cycles.
  localparam int c_RD_LAT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } trb_fsm_e;

endpackage

`default_nettype wire

// File: rtl/vit_trb_engine.sv
// ============================================================================
//  Module   : vit_trb_engine
//  Purpose  : Walks the decision store backwards, one decoded bit per step.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module vit_trb_engine
  import vit_trb_engine_pkg::*;
#(
  parameter int pSTATE_W = 6,
  parameter int pDATA_W  = 2**pSTATE_W,
  parameter int pADDR_W  = 8,
  parameter int pLEN_W   = pADDR_W + 1
) (
  input  logic                iclk,
  input  logic                ireset,
  input  logic                iclkena,
  input  logic                istart,
  input  logic [pADDR_W-1:0]  iend_addr,
  input  logic [pSTATE_W-1:0] istate,
  input  logic [pLEN_W-1:0]   ilen,
  input  logic [pLEN_W-1:0]   iskip,
  output logic [pADDR_W-1:0]  oraddr,
  input  logic [pDATA_W-1:0]  irdata,
  output logic                ordy,
  output logic                oval,
  output logic                odat,
  output logic                osop,
  output logic                oeop,
  output logic                odone,
  output logic [pSTATE_W-1:0] ostate
);

  trb_fsm_e            r_fsm;
  logic [pADDR_W-1:0]  r_addr;
  logic [pLEN_W-1:0]   r_cnt;
  logic [pLEN_W-1:0]   r_len;
  logic [pLEN_W-1:0]   r_skip;
  logic [pSTATE_W-1:0] r_st;
  logic [c_RD_LAT-1:0] r_pv;
  logic [pLEN_W-1:0]   r_pk [c_RD_LAT];
  logic                r_rdy, r_val, r_dat, r_sop, r_eop, r_done;
  logic [pSTATE_W-1:0] r_ostate;

  logic                w_issue;
  logic [pLEN_W-1:0]   w_k;
  logic                w_d;
  logic [pSTATE_W-1:0] w_nxt;
  logic                w_emit;
  logic                w_last;

  // Addresses never depend on state, so only bit selection sits in the loop.
  assign w_issue = (r_fsm == ST_FETCH);
  assign w_k     = r_pk[c_RD_LAT-1];
  assign w_d     = irdata[r_st];
  assign w_nxt   = {r_st[pSTATE_W-2:0], w_d};
  assign w_emit  = (w_k >= r_skip);
  assign w_last  = (w_k == r_len - (pLEN_W)'(1));

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      r_fsm    <= ST_IDLE;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_len    <= '0;
      r_skip   <= '0;
      r_st     <= '0;
      r_pv     <= '0;
      for (int i = 0; i < c_RD_LAT; i++) r_pk[i] <= '0;
      r_rdy    <= 1'b1;
      r_val    <= 1'b0;
      r_dat    <= 1'b0;
      r_sop    <= 1'b0;
      r_eop    <= 1'b0;
      r_done   <= 1'b0;
      r_ostate <= '0;
    end else if (iclkena) begin
      r_pv    <= {r_pv[c_RD_LAT-2:0], w_issue};
      r_pk[0] <= r_cnt;
      for (int i = 1; i < c_RD_LAT; i++) r_pk[i] <= r_pk[i-1];

      r_val  <= 1'b0;
      r_dat  <= 1'b0;
      r_sop  <= 1'b0;
      r_eop  <= 1'b0;
      r_done <= 1'b0;
      if (r_pv[c_RD_LAT-1]) begin
        r_st  <= w_nxt;
        r_val <= w_emit;
        r_dat <= w_emit & r_st[pSTATE_W-1];
        r_sop <= (w_k == r_skip);
        r_eop <= w_last & w_emit;
        if (w_last) begin
          r_done   <= 1'b1;
          r_ostate <= w_nxt;
        end
      end

      case (r_fsm)
        ST_IDLE: begin
          if (istart && (ilen != '0)) begin
            r_fsm  <= ST_FETCH;
            r_addr <= iend_addr;
            r_cnt  <= '0;
            r_st   <= istate;
            r_len  <= ilen;
            r_skip <= iskip;
            r_rdy  <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (r_cnt == r_len - (pLEN_W)'(1)) begin
            r_fsm <= ST_FLUSH;
          end else begin
            r_addr <= r_addr - (pADDR_W)'(1);
            r_cnt  <= r_cnt + (pLEN_W)'(1);
          end
        end
        ST_FLUSH: begin
          // The final step has just been emitted; nothing is left in flight.
          if (r_done) begin
            r_fsm <= ST_IDLE;
            r_rdy <= 1'b1;
          end
        end
        default: r_fsm <= ST_IDLE;
      endcase
    end
  end

  assign oraddr = r_addr;
  assign ordy   = r_rdy;
  assign oval   = r_val;
  assign odat   = r_dat;
  assign osop   = r_sop;
  assign oeop   = r_eop;
  assign odone  = r_done;
  assign ostate = r_ostate;

endmodule

`default_nettype wire

// File: tb/tb_vit_trb_engine.sv
// ============================================================================
//  Module   : tb_vit_trb_engine
//  Purpose  : Directed, table-driven bench for vit_trb_engine (3-bit state).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vit_trb_engine;

  localparam int SW = 3;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int LW = 5;

  logic          iclk = 1'b0;
  logic          ireset = 1'b1;
  logic          iclkena = 1'b1;
  logic          istart = 1'b0;
  logic [AW-1:0] iend_addr = '0;
  logic [SW-1:0] istate = '0;
  logic [LW-1:0] ilen = '0;
  logic [LW-1:0] iskip = '0;
  logic [AW-1:0] oraddr;
  logic [DW-1:0] irdata;
  logic          ordy, oval, odat, osop, oeop, odone;
  logic [SW-1:0] ostate;

  int n_run = 0;
  int n_fail = 0;

  vit_trb_engine #(.pSTATE_W(SW), .pDATA_W(DW), .pADDR_W(AW), .pLEN_W(LW)) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .istart(istart),
    .iend_addr(iend_addr), .istate(istate), .ilen(ilen), .iskip(iskip),
    .oraddr(oraddr), .irdata(irdata), .ordy(ordy), .oval(oval), .odat(odat),
    .osop(osop), .oeop(oeop), .odone(odone), .ostate(ostate)
  );

  always #5 iclk = ~iclk;

  // Behavioural decision RAM with 2-cycle read latency, gated like the engine.
  logic [DW-1:0] mem [16];
  logic [DW-1:0] ram_p1 = '0;
  logic [DW-1:0] ram_p2 = '0;
  always @(posedge iclk) begin
    if (iclkena) begin
      ram_p1 <= mem[oraddr];
      ram_p2 <= ram_p1;
    end
  end
  assign irdata = ram_p2;

  typedef struct {
    int            pat;
    logic [AW-1:0] ea;
    logic [SW-1:0] st;
    int            len;
    int            skip;
    int            frz;
    int            nb;
    logic [15:0]   bits;
    int            sop;
    int            eop;
    int            done;
    int            rdy;
    logic [SW-1:0] ost;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill(input int pat);
    for (int a = 0; a < 16; a++) begin
      case (pat)
        0:       mem[a] = 8'h00;
        1:       mem[a] = 8'hFF;
        default: mem[a] = 8'h01 << (a % 8);
      endcase
    end
  endtask

  function automatic logic [12:0] outs();
    return {ordy, oraddr, oval, odat, osop, oeop, odone, ostate};
  endfunction

  // Cycle 0 is the negedge-to-posedge window with istart high.
  task automatic run_vec(input vec_t v, input int idx);
    logic [AW-1:0] ga [16];
    logic [AW-1:0] ea;
    logic [15:0]   bits;
    logic [SW-1:0] ost;
    logic [12:0]   snap;
    int nb, sop, eop, done, rdy, amis;
    bit fin;
    fill(v.pat);
    nb = 0; bits = '0; sop = 0; eop = 0; done = 0; rdy = 0; ost = '0; fin = 0; amis = 0;
    for (int i = 0; i < 16; i++) ga[i] = '0;
    @(negedge iclk);
    iend_addr = v.ea; istate = v.st; ilen = LW'(v.len); iskip = LW'(v.skip); istart = 1'b1;
    for (int c = 1; c <= 60 && !fin; c++) begin
      @(negedge iclk);
      if (c == 1) istart = 1'b0;
      if (c <= v.len) ga[c-1] = oraddr;
      if (oval && nb < 16) begin bits[nb] = odat; nb++; end
      if (osop && sop == 0) sop = c;
      if (oeop && eop == 0) eop = c;
      if (odone && done == 0) begin done = c; ost = ostate; end
      if (ordy && rdy == 0) begin rdy = c; fin = 1; end
      if (c == v.frz) begin
        snap = outs();
        iclkena = 1'b0;
        for (int f = 0; f < 3; f++) begin
          @(negedge iclk);
          chk($sformatf("v%0d.freeze%0d", idx, f), 32'(outs()), 32'(snap));
        end
        iclkena = 1'b1;
      end
    end
    chk($sformatf("v%0d.finished", idx), 32'(fin), 32'd1);
    for (int i = 0; i < v.len; i++) begin
      ea = v.ea - AW'(i);
      if (ga[i] !== ea && amis == 0) begin
        amis = 1;
        $display("FAIL v%0d.addr[%0d]: got %0d expected %0d", idx, i, ga[i], ea);
      end
    end
    n_run++;
    if (amis != 0) n_fail++;
    chk($sformatf("v%0d.nbits", idx), 32'(nb), 32'(v.nb));
    chk($sformatf("v%0d.bits", idx), 32'(bits), 32'(v.bits));
    chk($sformatf("v%0d.sop_cyc", idx), 32'(sop), 32'(v.sop));
    chk($sformatf("v%0d.eop_cyc", idx), 32'(eop), 32'(v.eop));
    chk($sformatf("v%0d.done_cyc", idx), 32'(done), 32'(v.done));
    chk($sformatf("v%0d.rdy_cyc", idx), 32'(rdy), 32'(v.rdy));
    chk($sformatf("v%0d.ostate", idx), 32'(ost), 32'(v.ost));
  endtask

  initial begin
    logic [AW-1:0] prev_addr;
    //          pat ea     st      len skip frz nb bits         sop eop done rdy ost
    vecs[0] = '{0, 4'd9,  3'b000, 5,  2,   0,  3, 16'b0,       6,  8,  8,   9,  3'b000};
    vecs[1] = '{1, 4'd12, 3'b100, 4,  0,   0,  4, 16'b1001,    4,  7,  7,   8,  3'b111};
    vecs[2] = '{0, 4'd1,  3'b101, 4,  1,   0,  3, 16'b010,     5,  7,  7,   8,  3'b000};
    vecs[3] = '{1, 4'd5,  3'b010, 3,  5,   0,  0, 16'b0,       0,  0,  6,   7,  3'b111};
    vecs[4] = '{2, 4'd3,  3'b011, 3,  0,   0,  3, 16'b110,     4,  6,  6,   7,  3'b100};
    vecs[5] = '{0, 4'd0,  3'b111, 16, 14,  0,  2, 16'b0,       18, 19, 19,  20, 3'b000};
    vecs[6] = '{0, 4'd7,  3'b101, 4,  0,   5,  4, 16'b0101,    4,  7,  7,   8,  3'b000};

    fill(0);
    repeat (3) @(negedge iclk);
    chk("reset_outputs", 32'(outs()), 32'(13'b1_0000_00000_000));
    ireset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // ilen==0 must not start a job.
    @(negedge iclk);
    prev_addr = oraddr;
    iend_addr = 4'd9; ilen = '0; iskip = '0; istart = 1'b1;
    @(negedge iclk);
    istart = 1'b0;
    chk("len0.ordy", 32'(ordy), 32'd1);
    repeat (3) @(negedge iclk);
    chk("len0.oraddr", 32'(oraddr), 32'(prev_addr));
    chk("len0.oval", 32'(oval), 32'd0);

    // Busy restart is ignored; back-to-back start at cycle 4+ilen is taken.
    fill(0);
    @(negedge iclk);
    iend_addr = 4'd6; istate = '0; ilen = 5'd4; iskip = '0; istart = 1'b1;
    @(negedge iclk); istart = 1'b0;                                   // c1
    chk("busy.addr_c1", 32'(oraddr), 32'd6);
    @(negedge iclk);                                                  // c2
    iend_addr = 4'd10; ilen = 5'd2; istart = 1'b1;
    @(negedge iclk); istart = 1'b0;                                   // c3
    chk("busy.addr_c3", 32'(oraddr), 32'd4);
    @(negedge iclk);                                                  // c4
    chk("busy.addr_c4", 32'(oraddr), 32'd3);
    repeat (3) @(negedge iclk);                                       // c7
    chk("busy.done_c7", 32'(odone), 32'd1);
    @(negedge iclk);                                                  // c8
    chk("busy.rdy_c8", 32'(ordy), 32'd1);
    iend_addr = 4'd12; ilen = 5'd2; iskip = '0; istart = 1'b1;
    @(negedge iclk); istart = 1'b0;                                   // c9
    chk("b2b.addr_c9", 32'(oraddr), 32'd12);
    chk("b2b.rdy_c9", 32'(ordy), 32'd0);
    @(negedge iclk);                                                  // c10
    chk("b2b.addr_c10", 32'(oraddr), 32'd11);
    repeat (3) @(negedge iclk);                                       // c13
    chk("b2b.done_c13", 32'(odone), 32'd1);
    @(negedge iclk);                                                  // c14
    chk("b2b.rdy_c14", 32'(ordy), 32'd1);

    // Asynchronous reset in the middle of a job.
    fill(1);
    @(negedge iclk);
    iend_addr = 4'd3; istate = 3'b001; ilen = 5'd8; iskip = '0; istart = 1'b1;
    @(negedge iclk); istart = 1'b0;
    repeat (4) @(negedge iclk);
    chk("rst.busy_before", 32'({ordy, oval}), 32'b01);
    #2 ireset = 1'b1;
    #1 chk("rst.immediate", 32'(outs()), 32'(13'b1_0000_00000_000));
    @(negedge iclk); ireset = 1'b0;
    repeat (4) @(negedge iclk);
    chk("rst.idle_after", 32'(outs()), 32'(13'b1_0000_00000_000));
    run_vec(vecs[0], 7);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
